// File: rtl/wash_pkg.sv
// Shared encodings, default phase durations and model/phase lookup for the wash sequencer.
// Pure declarations and functions; no timing or flow control of its own.
package wash_pkg;

  typedef enum logic [2:0] {
    MODEL_WRS = 3'b000,
    MODEL_W   = 3'b001,
    MODEL_WR  = 3'b010,
    MODEL_R   = 3'b011,
    MODEL_RS  = 3'b100,
    MODEL_S   = 3'b101
  } model_e;

  typedef enum logic [1:0] {
    PROG_WASH  = 2'b00,
    PROG_RINSE = 2'b01,
    PROG_SPIN  = 2'b10
  } prog_e;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'b00,
    RS_RUN   = 2'b01,
    RS_PAUSE = 2'b10
  } run_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam int DEF_TICK_DIV = 100_000_000;
  localparam int DEF_WASH_T   = 9;
  localparam int DEF_RINSE_T  = 6;
  localparam int DEF_SPIN_T   = 3;

  typedef struct packed {
    prog_e      first;
    prog_e      next;
    logic       has_next;
    logic [7:0] total;
  } model_info_t;

  function automatic model_e model_succ(model_e m);
    model_e r;
    case (m)
      MODEL_WRS: r = MODEL_W;
      MODEL_W:   r = MODEL_WR;
      MODEL_WR:  r = MODEL_R;
      MODEL_R:   r = MODEL_RS;
      MODEL_RS:  r = MODEL_S;
      default:   r = MODEL_WRS;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] phase_dur(prog_e p, logic [7:0] wt, logic [7:0] rt,
                                           logic [7:0] st);
    logic [7:0] d;
    case (p)
      PROG_WASH:  d = wt;
      PROG_RINSE: d = rt;
      default:    d = st;
    endcase
    return d;
  endfunction

  // Phases always run in wash -> rinse -> spin order; a model is a contiguous subset.
  function automatic model_info_t model_info(model_e m, prog_e cur, logic [7:0] wt,
                                             logic [7:0] rt, logic [7:0] st);
    model_info_t info;
    logic uses_w, uses_r, uses_s;
    uses_w = m inside {MODEL_WRS, MODEL_W, MODEL_WR};
    uses_r = m inside {MODEL_WRS, MODEL_WR, MODEL_R, MODEL_RS};
    uses_s = m inside {MODEL_WRS, MODEL_RS, MODEL_S};
    info.first    = uses_w ? PROG_WASH : (uses_r ? PROG_RINSE : PROG_SPIN);
    info.total    = (uses_w ? wt : 8'd0) + (uses_r ? rt : 8'd0) + (uses_s ? st : 8'd0);
    info.next     = cur;
    info.has_next = 1'b0;
    if (cur == PROG_WASH && uses_r) begin
      info.next     = PROG_RINSE;
      info.has_next = 1'b1;
    end else if (cur == PROG_RINSE && uses_s) begin
      info.next     = PROG_SPIN;
      info.has_next = 1'b1;
    end
    return info;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Free-running 0..TICK_DIV-1 divider producing a one-cycle tick on the terminal count.
// Tick is combinational from the count; count holds whenever enable is low.
module sec_tick #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Wash-cycle program sequencer: model select, phase timing on a 1 Hz tick, run/pause/done.
// All outputs registered; a request pulse is reflected one cycle after the edge that samples it.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int WASH_T   = DEF_WASH_T,
  parameter int RINSE_T  = DEF_RINSE_T,
  parameter int SPIN_T   = DEF_SPIN_T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       start_req,
  input  logic       model_req,
  output logic [2:0] current_model,
  output logic [1:0] current_program,
  output logic [1:0] run_state,
  output logic       finish,
  output logic [7:0] remain_s,
  output logic [7:0] phase_remain_s
);

  localparam logic [7:0] WASH_D  = 8'(WASH_T);
  localparam logic [7:0] RINSE_D = 8'(RINSE_T);
  localparam logic [7:0] SPIN_D  = 8'(SPIN_T);

  state_e      state_q, state_d;
  model_e      model_q, model_d, model_sel;
  prog_e       prog_q, prog_d;
  run_state_e  run_state_q, run_state_d;
  logic        finish_q, finish_d;
  logic [7:0]  remain_q, remain_d;
  logic [7:0]  phase_q, phase_d;
  model_info_t info;
  logic        tick;
  logic        div_clear;

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear || !power_on),
    .enable (state_q == ST_RUN),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    model_d     = model_q;
    prog_d      = prog_q;
    run_state_d = run_state_q;
    finish_d    = finish_q;
    remain_d    = remain_q;
    phase_d     = phase_q;
    div_clear   = 1'b0;

    // The model whose info is needed this cycle: the stepped one in IDLE, 000 on leaving DONE.
    model_sel = model_q;
    if (state_q == ST_IDLE && model_req && !start_req) begin
      model_sel = model_succ(model_q);
    end else if (state_q == ST_DONE && start_req) begin
      model_sel = MODEL_WRS;
    end
    info = model_info(model_sel, prog_q, WASH_D, RINSE_D, SPIN_D);

    case (state_q)
      ST_IDLE: begin
        model_d  = model_sel;
        prog_d   = info.first;
        remain_d = info.total;
        phase_d  = 8'd0;
        if (start_req) begin
          state_d     = ST_RUN;
          run_state_d = RS_RUN;
          phase_d     = phase_dur(info.first, WASH_D, RINSE_D, SPIN_D);
          div_clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (remain_q != 8'd0) remain_d = remain_q - 8'd1;
          if (phase_q > 8'd1) begin
            phase_d = phase_q - 8'd1;
          end else if (info.has_next) begin
            prog_d  = info.next;
            phase_d = phase_dur(info.next, WASH_D, RINSE_D, SPIN_D);
          end else begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
            remain_d = 8'd0;
            phase_d  = 8'd0;
          end
        end
        // A start on the final tick is dropped: DONE takes precedence.
        if (start_req && state_d == ST_RUN) begin
          state_d     = ST_PAUSE;
          run_state_d = RS_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_req) begin
          state_d     = ST_RUN;
          run_state_d = RS_RUN;
        end
      end
      default: begin
        if (start_req) begin
          state_d     = ST_IDLE;
          model_d     = model_sel;
          prog_d      = info.first;
          remain_d    = info.total;
          phase_d     = 8'd0;
          run_state_d = RS_IDLE;
          finish_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !power_on) begin
      state_q     <= ST_IDLE;
      model_q     <= MODEL_WRS;
      prog_q      <= PROG_WASH;
      run_state_q <= RS_IDLE;
      finish_q    <= 1'b0;
      remain_q    <= 8'd0;
      phase_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      model_q     <= model_d;
      prog_q      <= prog_d;
      run_state_q <= run_state_d;
      finish_q    <= finish_d;
      remain_q    <= remain_d;
      phase_q     <= phase_d;
    end
  end

  assign current_model   = model_q;
  assign current_program = prog_q;
  assign run_state       = run_state_q;
  assign finish          = finish_q;
  assign remain_s        = remain_q;
  assign phase_remain_s  = phase_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: fixed vector table, hand-written timing sequences, and random
// stimulus checked against a reference that tracks elapsed RUN cycles.
module tb_wash_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset, power_on, start_req, model_req;
  logic [2:0] current_model;
  logic [1:0] current_program, run_state;
  logic       finish;
  logic [7:0] remain_s, phase_remain_s;
  logic [23:0] dut_out;

  wash_sequencer #(.TICK_DIV(TD), .WASH_T(3), .RINSE_T(2), .SPIN_T(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .power_on        (power_on),
    .start_req       (start_req),
    .model_req       (model_req),
    .current_model   (current_model),
    .current_program (current_program),
    .run_state       (run_state),
    .finish          (finish),
    .remain_s        (remain_s),
    .phase_remain_s  (phase_remain_s)
  );

  always #5 clk = ~clk;

  assign dut_out = {current_model, current_program, run_state, finish, remain_s, phase_remain_s};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: mode 0 idle, 1 run, 2 pause, 3 done; progress is a count of RUN cycles.
  int m_mode = 0;
  int m_model = 0;
  int m_cycles = 0;
  bit m_fresh = 1'b1;

  function automatic bit uses(int mdl, int p);
    int mask;
    case (mdl)
      0: mask = 7;
      1: mask = 4;
      2: mask = 6;
      3: mask = 2;
      4: mask = 3;
      default: mask = 1;
    endcase
    return mask[2-p];
  endfunction

  function automatic int dur(int p);
    return (p == 0) ? 3 : 2;
  endfunction

  function automatic int total(int mdl);
    int t = 0;
    for (int p = 0; p < 3; p++) if (uses(mdl, p)) t += dur(p);
    return t;
  endfunction

  task automatic ref_edge(input bit r, input bit p, input bit s, input bit m);
    if (r || !p) begin
      m_mode = 0; m_model = 0; m_cycles = 0; m_fresh = 1'b1;
    end else begin
      m_fresh = 1'b0;
      case (m_mode)
        0: if (s) begin m_mode = 1; m_cycles = 0; end
           else if (m) m_model = (m_model + 1) % 6;
        1: begin
          m_cycles++;
          if (m_cycles == total(m_model) * TD) m_mode = 3;
          else if (s) m_mode = 2;
        end
        2: if (s) m_mode = 1;
        default: if (s) begin m_mode = 0; m_model = 0; end
      endcase
    end
  endtask

  function automatic logic [23:0] ref_out();
    int sec, cum, prog, rs, rem, ph, fin;
    bit found;
    if (m_fresh) return 24'd0;
    prog = 0; rs = 0; fin = 0; rem = 0; ph = 0; cum = 0; found = 1'b0;
    case (m_mode)
      0: begin
        for (int p = 2; p >= 0; p--) if (uses(m_model, p)) prog = p;
        rem = total(m_model);
      end
      3: begin
        for (int p = 0; p < 3; p++) if (uses(m_model, p)) prog = p;
        rs = 1; fin = 1;
      end
      default: begin
        sec = m_cycles / TD;
        rem = total(m_model) - sec;
        rs  = (m_mode == 1) ? 1 : 2;
        for (int p = 0; p < 3; p++) begin
          if (uses(m_model, p) && !found) begin
            if (sec < cum + dur(p)) begin
              prog = p; ph = cum + dur(p) - sec; found = 1'b1;
            end else begin
              cum += dur(p);
            end
          end
        end
      end
    endcase
    return {3'(m_model), 2'(prog), 2'(rs), 1'(fin), 8'(rem), 8'(ph)};
  endfunction

  task automatic step(input bit r, input bit p, input bit s, input bit m);
    reset = r; power_on = p; start_req = s; model_req = m;
    @(posedge clk);
    ref_edge(r, p, s, m);
    #1;
    reset = 1'b0; start_req = 1'b0; model_req = 1'b0;
  endtask

  typedef struct {
    bit r, p, s, m;
    logic [2:0] mdl;
    logic [1:0] prog, rs;
    logic       fin;
    logic [7:0] rem, ph;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int t_rinse, t_spin, t_done, frozen_bad;
    reset = 1'b1; power_on = 1'b1; start_req = 1'b0; model_req = 1'b0;

    vecs[0]  = '{1, 1, 0, 0, 3'd0, 2'd0, 2'd0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 1'b0, 8'd7, 8'd0};
    vecs[2]  = '{0, 1, 0, 1, 3'd1, 2'd0, 2'd0, 1'b0, 8'd3, 8'd0};
    vecs[3]  = '{0, 1, 0, 1, 3'd2, 2'd0, 2'd0, 1'b0, 8'd5, 8'd0};
    vecs[4]  = '{0, 1, 0, 1, 3'd3, 2'd1, 2'd0, 1'b0, 8'd2, 8'd0};
    vecs[5]  = '{0, 1, 0, 1, 3'd4, 2'd1, 2'd0, 1'b0, 8'd4, 8'd0};
    vecs[6]  = '{0, 1, 0, 1, 3'd5, 2'd2, 2'd0, 1'b0, 8'd2, 8'd0};
    vecs[7]  = '{0, 1, 0, 1, 3'd0, 2'd0, 2'd0, 1'b0, 8'd7, 8'd0};
    vecs[8]  = '{0, 1, 1, 1, 3'd0, 2'd0, 2'd1, 1'b0, 8'd7, 8'd3};
    vecs[9]  = '{0, 1, 0, 1, 3'd0, 2'd0, 2'd1, 1'b0, 8'd7, 8'd3};
    vecs[10] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd1, 1'b0, 8'd7, 8'd3};
    vecs[11] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd1, 1'b0, 8'd7, 8'd3};
    vecs[12] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd1, 1'b0, 8'd6, 8'd2};
    vecs[13] = '{0, 1, 1, 0, 3'd0, 2'd0, 2'd2, 1'b0, 8'd6, 8'd2};
    vecs[14] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd2, 1'b0, 8'd6, 8'd2};
    vecs[15] = '{0, 1, 1, 0, 3'd0, 2'd0, 2'd1, 1'b0, 8'd6, 8'd2};
    vecs[16] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd1, 1'b0, 8'd6, 8'd2};
    vecs[17] = '{0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 1'b0, 8'd0, 8'd0};
    vecs[18] = '{0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 1'b0, 8'd7, 8'd0};

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].p, vecs[i].s, vecs[i].m);
      check($sformatf("vec%0d", i), dut_out,
            {vecs[i].mdl, vecs[i].prog, vecs[i].rs, vecs[i].fin, vecs[i].rem, vecs[i].ph});
    end

    // Full model-000 run: phase boundaries at 12 and 20 cycles, done at 28.
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    check("start_run_state", run_state, 2'b01);
    t_rinse = -1; t_spin = -1; t_done = -1;
    for (int e = 1; e <= 40; e++) begin
      step(0, 1, 0, 0);
      check("run000", dut_out, ref_out());
      if (t_rinse < 0 && current_program == 2'b01) t_rinse = e;
      if (t_spin < 0 && current_program == 2'b10) t_spin = e;
      if (finish === 1'b1) begin t_done = e; break; end
    end
    check("rinse_at", t_rinse, 12);
    check("spin_at", t_spin, 20);
    check("done_at", t_done, 28);
    check("done_remain", {remain_s, phase_remain_s, run_state}, {8'd0, 8'd0, 2'b01});
    step(0, 1, 1, 0);
    check("done_to_idle", {current_model, finish, remain_s, run_state}, {3'd0, 1'b0, 8'd7, 2'b00});

    // Pause at cycle 6, resume 10 cycles later: done slips by exactly 10.
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    t_done = -1; frozen_bad = 0;
    for (int e = 1; e <= 60; e++) begin
      step(0, 1, (e == 6 || e == 16), 0);
      check("pause_seq", dut_out, ref_out());
      if (e >= 6 && e <= 15 &&
          (remain_s !== 8'd6 || phase_remain_s !== 8'd2 || run_state !== 2'b10)) frozen_bad++;
      if (finish === 1'b1) begin t_done = e; break; end
    end
    check("pause_frozen", frozen_bad, 0);
    check("pause_done_at", t_done, 38);

    // Model 101 with start_req on the final tick: DONE wins, start not honoured.
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 1);
    check("model101", {current_model, current_program, remain_s}, {3'd5, 2'd2, 8'd2});
    step(0, 1, 1, 0);
    for (int e = 1; e <= 8; e++) begin
      step(0, 1, (e == 8), 0);
      check("spin_seq", dut_out, ref_out());
    end
    check("final_tick_done", {finish, run_state, remain_s}, {1'b1, 2'b01, 8'd0});
    step(0, 1, 0, 0);
    check("done_holds", {finish, current_program}, {1'b1, 2'b10});
    step(0, 1, 1, 0);
    check("done_exit", {current_model, finish, run_state, remain_s}, {3'd0, 1'b0, 2'b00, 8'd7});

    // Power drop mid-run on model 100.
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    check("pre_drop_run", {current_model, run_state}, {3'd4, 2'b01});
    step(0, 0, 0, 0);
    check("power_drop", dut_out, 24'd0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    check("power_restore", {run_state, current_model, remain_s, finish}, {2'b00, 3'd0, 8'd7, 1'b0});

    // Random traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 150) != 0,
           ($urandom % 10) == 0, ($urandom % 4) == 0);
      check("random", dut_out, ref_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer that owns the wash-cycle state of the washing machine: it holds the selected model, runs its phases (wash / rinse / spin) against a 1 Hz time base derived from `clk`, and tracks run/pause/finish. It sits directly upstream of the front-panel light controller. It drives that block's `current_model`, `current_program`, `run_state` and `finish` inputs, and also exports remaining-time counts for the display.

## Interface
- `TICK_DIV`, 100_000_000: `clk` cycles per second tick; must be ≥ 2.
- `WASH_T`, 9: wash phase duration in seconds; must be ≥ 1.
- `RINSE_T`, 6: rinse phase duration in seconds; must be ≥ 1.
- `SPIN_T`, 3: spin phase duration in seconds; must be ≥ 1. `WASH_T+RINSE_T+SPIN_T` must be ≤ 255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `power_on`  in  1  level; 0 forces the reset state every cycle.
- `start_req`  in  1  single-cycle pulse (debounced upstream); starts, pauses or resumes.
- `model_req`  in  1  single-cycle pulse; advances the model, honoured only in IDLE.
- `current_model`  out  3  000 wash-rinse-spin, 001 wash, 010 wash-rinse, 011 rinse, 100 rinse-spin, 101 spin.
- `current_program`  out  2  00 wash, 01 rinse, 10 spin.
- `run_state`  out  2  00 idle, 01 running, 10 paused.
- `finish`  out  1  high while in DONE.
- `remain_s`  out  8  total seconds left in the program.
- `phase_remain_s`  out  8  seconds left in the current phase.

## Operation
- State machine states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset value of every output, whether from `reset` or `power_on`=0: `current_model`=000, `current_program`=00, `run_state`=00, `finish`=0, `remain_s`=0, `phase_remain_s`=0. The tick divider is cleared and the state is IDLE. `reset` has priority over `power_on`.
- IDLE:
  - `model_req` advances the model 000→001→…→101→000.
  - `current_program` shows the model's first phase.
  - `remain_s` shows the model's total time. The total is the sum of the durations of the phases the model runs.
  - `start_req` moves to RUN. It loads `phase_remain_s` with the first phase duration, sets `run_state`=01 and clears the divider.
- IDLE with `start_req` and `model_req` in the same cycle: start wins and the model is unchanged.
- RUN:
  - The divider counts 0..TICK_DIV-1. A tick occurs on the cycle it equals TICK_DIV-1, and the divider then wraps to 0.
  - On a tick, `remain_s` and `phase_remain_s` each decrement by 1.
  - On a tick with `phase_remain_s`=1, the block advances to the next phase of the model and loads that phase's duration. If no phase follows, it enters DONE.
- RUN with `start_req`: go to PAUSE with `run_state`=10. The divider and both counters hold their values.
- PAUSE with `start_req`: return to RUN with `run_state`=01. The divider resumes from its held value.
- DONE:
  - `finish`=1, `run_state` stays 01, and `remain_s`=`phase_remain_s`=0.
  - `current_program` holds the last phase.
  - `start_req` returns to IDLE and sets `current_model`=000.
- `model_req` is ignored in RUN, PAUSE and DONE.
- A `start_req` coinciding with the final tick is applied after the tick. DONE is entered, and the start is honoured only if it arrives on a later cycle.
- No arithmetic underflow is possible: counters decrement only when they are ≥ 1.

## Timing
- Pulse sampled at edge n produces the new outputs visible after edge n, i.e. one cycle of latency.
- The first decrement occurs TICK_DIV cycles after the edge that accepted `start_req` from IDLE.
- A phase of T seconds occupies exactly T·TICK_DIV RUN cycles. Cycles spent in PAUSE are not counted.
- A phase transition and its decrement occur on the same edge. `current_program` and `phase_remain_s` update together.
- A `reset` or power drop during RUN or PAUSE reaches IDLE on the next edge, and all progress is lost.

## Structure
- Shared package `wash_pkg` holds:
  - model, program and run-state encodings;
  - the default phase durations;
  - a function that returns first phase, next phase and total time for a given model.
- One sub-module, `sec_tick`: the divider with `clk`, `reset`, `clear`, `enable` inputs and a `tick` output. It is reused by the display logic.

## Test plan
Scenarios use TICK_DIV=4, WASH_T=3, RINSE_T=2, SPIN_T=2.
- Reset, then idle: all outputs at their reset values. Three `model_req` pulses → `current_model`=011, `current_program`=01, `remain_s`=2.
- Model 000, `start_req`: `run_state`=01 next cycle. `current_program` goes 00→01 after 12 cycles, then 01→10 after 8 more. `finish`=1 at cycle 28 with `remain_s`=0.
- Model 000, pause at cycle 6 and resume 10 cycles later: `remain_s` and `phase_remain_s` frozen at 6 and 2 during the pause. `finish` asserts at cycle 28+10.
- Model 101 wraps: six `model_req` pulses from 000 → 000. `model_req` during RUN leaves the model unchanged. `start_req` and `model_req` in the same cycle in IDLE → RUN with the model unchanged.
- DONE then `start_req` → IDLE with `current_model`=000, `finish`=0, `remain_s`=7.
- `power_on` dropped mid-RUN (model 100) → every output at its reset value the next cycle. Restoring `power_on` with no `start_req` leaves the block in IDLE.
